// File: rtl/wb_decode5x32_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_decode5x32_if
//  Description : Bundle of the write-back request channel and the decoded
//                register-file write port used by wb_decode5x32.
//                  wr_valid_in / wr_ready_out : request handshake
//                  wr_addr_in  / wr_data_in   : destination register and data
//                  rf_busy_in                 : register file stall
//                  rf_we_out   / rf_data_out  : one-hot write enable and data
//                  count_out                  : buffered entry count (0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_decode5x32_if #(
  parameter int DATA_W = 64
);
  logic              wr_valid_in;
  logic              wr_ready_out;
  logic [4:0]        wr_addr_in;
  logic [DATA_W-1:0] wr_data_in;
  logic              rf_busy_in;
  logic [31:0]       rf_we_out;
  logic [DATA_W-1:0] rf_data_out;
  logic [1:0]        count_out;

  // Producer of write-back requests / consumer of register-file writes.
  modport master (
    output wr_valid_in, wr_addr_in, wr_data_in, rf_busy_in,
    input  wr_ready_out, rf_we_out, rf_data_out, count_out
  );

  // The decoder itself.
  modport slave (
    input  wr_valid_in, wr_addr_in, wr_data_in, rf_busy_in,
    output wr_ready_out, rf_we_out, rf_data_out, count_out
  );
endinterface
`default_nettype wire

// File: rtl/wb_decode5x32.sv
`default_nettype none
// ============================================================================
//  Module      : wb_decode5x32
//  Description : Write-back decoder. Buffers up to two {addr, data} write-back
//                requests in a FIFO and drains them, one per cycle, to a
//                32-entry register file as a one-hot write enable plus data.
//                Writes to the zero register (XZR_ADDR) are accepted and
//                dropped without being buffered.
//  Ports       : clk    - rising-edge clock
//                reset  - synchronous active-high reset
//                bus    - wb_decode5x32_if.slave (request channel, register
//                         file write port, count)
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_decode5x32 #(
  parameter int         DATA_W   = 64,
  parameter logic [4:0] XZR_ADDR = 5'd31
) (
  input  logic               clk,
  input  logic               reset,
  wb_decode5x32_if.slave     bus
);

  localparam logic [1:0]  C_DEPTH   = 2'd2;
  localparam logic [31:0] C_ONE_HOT = 32'd1;

  // FIFO storage and bookkeeping
  logic [4:0]        r_addr [2];
  logic [DATA_W-1:0] r_data [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;

  logic              w_ready;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;

  // No pass-through when full: readiness depends only on stored count, so a
  // pop in the same cycle does not open a slot for an incoming request.
  assign w_ready  = !reset && (r_count < C_DEPTH);
  assign w_accept = bus.wr_valid_in && w_ready;
  // Zero-register writes complete the handshake but never enter the FIFO.
  assign w_push   = w_accept && (bus.wr_addr_in != XZR_ADDR);
  assign w_pop    = (r_count != 2'd0) && !bus.rf_busy_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_wptr <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: an entry is only visible while counted.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wptr] <= bus.wr_addr_in;
      r_data[r_wptr] <= bus.wr_data_in;
    end
  end

  always_comb begin
    bus.rf_we_out   = 32'h0;
    bus.rf_data_out = '0;
    if (w_pop) begin
      bus.rf_we_out   = C_ONE_HOT << r_addr[r_rptr];
      bus.rf_data_out = r_data[r_rptr];
    end
  end

  assign bus.wr_ready_out = w_ready;
  assign bus.count_out    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_decode5x32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_decode5x32
//  Description : Self-checking bench for wb_decode5x32. Accepted non-XZR
//                requests are queued as expected register-file writes; a
//                monitor pops and compares whenever the DUT asserts a write
//                enable, and checks the one-hot rule every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_decode5x32;

  localparam int         DATA_W   = 64;
  localparam logic [4:0] XZR_ADDR = 5'd31;

  typedef struct packed {
    logic [4:0]        addr;
    logic [DATA_W-1:0] data;
  } item_t;

  logic clk;
  logic reset;

  wb_decode5x32_if #(.DATA_W(DATA_W)) ifc ();

  wb_decode5x32 #(
    .DATA_W  (DATA_W),
    .XZR_ADDR(XZR_ADDR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  item_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    m_cnt   = 0;   // bench model of the buffered entry count
  int    n_sent  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge with inputs stable; advances through the next
  // rising edge and updates the model.
  task automatic clk_edge();
    logic  acc;
    logic  pop;
    item_t it;
    chk("ready", 64'(ifc.wr_ready_out), 64'((!reset && m_cnt < 2) ? 1 : 0));
    chk("count", 64'(ifc.count_out), 64'(m_cnt));
    acc     = ifc.wr_valid_in && !reset && (m_cnt < 2);
    pop     = (m_cnt > 0) && !ifc.rf_busy_in;
    it.addr = ifc.wr_addr_in;
    it.data = ifc.wr_data_in;
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (acc) n_sent++;
      if (acc && it.addr != XZR_ADDR) begin
        q.push_back(it);
        m_cnt++;
      end
      if (pop) m_cnt--;
    end
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
    clk_edge();
  endtask

  task automatic put(input logic [4:0] a, input logic [DATA_W-1:0] d);
    ifc.wr_valid_in = 1'b1;
    ifc.wr_addr_in  = a;
    ifc.wr_data_in  = d;
    cyc();
    ifc.wr_valid_in = 1'b0;
  endtask

  // Checks the current-cycle outputs; call right after reaching a negedge.
  task automatic expect_out(input string name, input logic [31:0] we,
                            input logic [DATA_W-1:0] d, input int cnt);
    chk({name, "_we"},    64'(ifc.rf_we_out), 64'(we));
    chk({name, "_data"},  ifc.rf_data_out, d);
    chk({name, "_count"}, 64'(ifc.count_out), 64'(cnt));
  endtask

  // Monitor: scoreboard pop on every emitted write, one-hot rule every cycle.
  always @(negedge clk) begin
    item_t e;
    chk("onehot0", 64'($onehot0(ifc.rf_we_out)), 64'd1);
    chk("xzr_bit", 64'(ifc.rf_we_out[XZR_ADDR]), 64'd0);
    if (ifc.rf_we_out != 32'h0) begin
      if (q.size() == 0) begin
        chk("unexpected_write", 64'(ifc.rf_we_out), 64'd0);
      end else begin
        e = q.pop_front();
        chk("sb_we",   64'(ifc.rf_we_out), 64'(32'd1 << e.addr));
        chk("sb_data", ifc.rf_data_out, e.data);
      end
    end else begin
      chk("idle_data", ifc.rf_data_out, '0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    reset           = 1'b1;
    ifc.wr_valid_in = 1'b0;
    ifc.wr_addr_in  = 5'd0;
    ifc.wr_data_in  = '0;
    ifc.rf_busy_in  = 1'b0;

    // Reset, with a request offered during reset that must not be taken.
    cyc();
    ifc.wr_valid_in = 1'b1;
    ifc.wr_addr_in  = 5'd4;
    ifc.wr_data_in  = 64'h44;
    @(negedge clk);
    expect_out("rst", 32'h0, '0, 0);
    chk("rst_ready", 64'(ifc.wr_ready_out), 64'd0);
    clk_edge();
    reset           = 1'b0;
    ifc.wr_valid_in = 1'b0;
    @(negedge clk);
    expect_out("post_rst", 32'h0, '0, 0);
    chk("post_rst_ready", 64'(ifc.wr_ready_out), 64'd1);
    clk_edge();

    // Single write, minimum latency, exactly one cycle.
    put(5'd5, 64'hDEAD_BEEF);
    @(negedge clk);
    expect_out("single", 32'h0000_0020, 64'hDEAD_BEEF, 1);
    clk_edge();
    @(negedge clk);
    expect_out("single_after", 32'h0, '0, 0);
    clk_edge();

    // Fill while busy, third request refused, drain in order.
    ifc.rf_busy_in = 1'b1;
    put(5'd1, 64'h111);
    put(5'd2, 64'h222);
    ifc.wr_valid_in = 1'b1;
    ifc.wr_addr_in  = 5'd3;
    ifc.wr_data_in  = 64'h333;
    @(negedge clk);
    expect_out("full", 32'h0, '0, 2);
    chk("full_ready", 64'(ifc.wr_ready_out), 64'd0);
    clk_edge();
    ifc.wr_valid_in = 1'b0;
    ifc.rf_busy_in  = 1'b0;
    @(negedge clk);
    expect_out("drain1", 32'h2, 64'h111, 2);
    clk_edge();
    @(negedge clk);
    expect_out("drain2", 32'h4, 64'h222, 1);
    clk_edge();
    @(negedge clk);
    expect_out("drained", 32'h0, '0, 0);
    clk_edge();

    // Zero-register write is consumed and dropped.
    ifc.wr_valid_in = 1'b1;
    ifc.wr_addr_in  = 5'd31;
    ifc.wr_data_in  = 64'h1;
    @(negedge clk);
    chk("xzr_ready", 64'(ifc.wr_ready_out), 64'd1);
    clk_edge();
    ifc.wr_valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      expect_out("xzr_quiet", 32'h0, '0, 0);
      clk_edge();
    end

    // Simultaneous push and pop with one entry buffered.
    ifc.rf_busy_in = 1'b1;
    put(5'd3, 64'h33);
    ifc.rf_busy_in  = 1'b0;
    ifc.wr_valid_in = 1'b1;
    ifc.wr_addr_in  = 5'd7;
    ifc.wr_data_in  = 64'h77;
    @(negedge clk);
    expect_out("pp_pop3", 32'h8, 64'h33, 1);
    clk_edge();
    ifc.wr_valid_in = 1'b0;
    @(negedge clk);
    expect_out("pp_pop7", 32'h80, 64'h77, 1);
    clk_edge();
    @(negedge clk);
    expect_out("pp_empty", 32'h0, '0, 0);
    clk_edge();

    // Same register written twice: emitted in order, head held while busy.
    ifc.rf_busy_in = 1'b1;
    put(5'd6, 64'hA);
    put(5'd6, 64'hB);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_out("hold", 32'h0, '0, 2);
      clk_edge();
    end
    ifc.rf_busy_in = 1'b0;
    @(negedge clk);
    expect_out("same1", 32'h40, 64'hA, 2);
    clk_edge();
    @(negedge clk);
    expect_out("same2", 32'h40, 64'hB, 1);
    clk_edge();

    // Reset with a full FIFO discards both entries.
    ifc.rf_busy_in = 1'b1;
    put(5'd9, 64'h99);
    put(5'd10, 64'hAA);
    reset = 1'b1;
    @(negedge clk);
    expect_out("full_rst", 32'h0, '0, 2);
    clk_edge();
    reset          = 1'b0;
    ifc.rf_busy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_out("after_full_rst", 32'h0, '0, 0);
      chk("after_full_rst_ready", 64'(ifc.wr_ready_out), 64'd1);
      clk_edge();
    end

    // Random stream of 1000 accepted requests with random stalls.
    n_sent = 0;
    while (n_sent < 1000) begin
      ifc.wr_valid_in = ($urandom_range(3) != 0);
      ifc.wr_addr_in  = 5'($urandom_range(31));
      ifc.wr_data_in  = {$urandom(), $urandom()};
      ifc.rf_busy_in  = ($urandom_range(2) == 0);
      cyc();
    end
    ifc.wr_valid_in = 1'b0;
    ifc.rf_busy_in  = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("sb_empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_decode5x32.md
WB_DECODE5X32 -- requirements
Module: wb_decode5x32

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the write-back data width in bits.
REQ-002 The block SHALL have parameter XZR_ADDR, default 5'd31, giving the zero-register address whose writes are discarded.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port wr_valid_in, input, 1: a write-back request is present.
REQ-006 Port wr_ready_out, output, 1: the block can accept a request this cycle.
REQ-007 Port wr_addr_in, input, 5: destination register number.
REQ-008 Port wr_data_in, input, DATA_W: write-back data.
REQ-009 Port rf_busy_in, input, 1: the register file cannot take a write this cycle.
REQ-010 Port rf_we_out, output, 32: one-hot register write enables.
REQ-011 Port rf_data_out, output, DATA_W: data for the enabled register.
REQ-012 Port count_out, output, 2: number of buffered entries (0..2).

Function
REQ-013 The block SHALL hold a 2-entry FIFO of {addr, data} with read pointer, write pointer and a 0..2 count.
REQ-014 A request SHALL be accepted when wr_valid_in=1 and wr_ready_out=1 at a rising edge.
REQ-015 wr_ready_out SHALL be 1 exactly when reset=0 and count<2; there is no same-cycle pass-through when full.
REQ-016 An accepted request with wr_addr_in==XZR_ADDR SHALL be consumed (handshake completes) but SHALL NOT be enqueued.
REQ-017 Push SHALL be asserted when a request is accepted and wr_addr_in!=XZR_ADDR.
REQ-018 Pop SHALL be asserted when count>0 and rf_busy_in=0.
REQ-019 While pop is asserted, rf_we_out SHALL equal (1 << head.addr) and rf_data_out SHALL equal head.data, combinationally from FIFO state.
REQ-020 While pop is not asserted, rf_we_out SHALL be 32'h0 and rf_data_out SHALL be 0.
REQ-021 rf_we_out SHALL never have more than one bit set, and bit XZR_ADDR SHALL never be set.
REQ-022 Latency: a request accepted at edge N SHALL appear on rf_we_out no earlier than the cycle after edge N (one cycle minimum with an empty FIFO and rf_busy_in=0).
REQ-023 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-024 Push alone SHALL increment count, pop alone SHALL decrement it, and pointers SHALL wrap modulo 2.
REQ-025 Ordering SHALL be strict FIFO; a later write to the same register SHALL be emitted after the earlier one.
REQ-026 rf_busy_in=1 SHALL hold the head entry unchanged for any number of cycles, with rf_we_out=0 throughout.
REQ-027 count_out SHALL equal the registered count.

Reset
REQ-028 When reset=1 at a rising edge, count, read pointer and write pointer SHALL become 0, and stored entries SHALL be treated as invalid.
REQ-029 During and after reset until the first push: rf_we_out=0, rf_data_out=0, count_out=0; wr_ready_out SHALL be 0 while reset=1 and 1 after it.
REQ-030 Reset asserted with a full FIFO SHALL discard both entries; no rf_we_out pulse SHALL occur for them after reset is released.
REQ-031 A request presented in the same cycle as reset=1 SHALL NOT be accepted.

Verification
REQ-032 After reset, empty FIFO, rf_busy_in=0: push addr 5, data 64'hDEAD_BEEF -> the next cycle rf_we_out=32'h0000_0020, rf_data_out=64'hDEAD_BEEF for exactly one cycle; count_out returns to 0.
REQ-033 With rf_busy_in=1, push addr 1 then addr 2 -> count_out=2 and wr_ready_out=0; a third request is not accepted; release busy -> rf_we_out=32'h2, then 32'h4 on consecutive cycles.
REQ-034 Push addr 31, data 64'h1 -> handshake completes, count_out stays 0, and rf_we_out remains 0 for the following 4 cycles.
REQ-035 With count=1 and rf_busy_in=0, push addr 7 in the same cycle as a pop of addr 3 -> count_out stays 1; rf_we_out=32'h8, then 32'h80 on the next cycle.
REQ-036 Fill the FIFO (addrs 9 and 10, busy=1), assert reset for one cycle, then release with busy=0 -> rf_we_out stays 0, count_out=0, and wr_ready_out=1.
REQ-037 Random stream of 1000 requests with random busy: emitted (addr, data) sequence equals the non-XZR accepted sequence, and one-hot is checked every cycle.
